// File: rtl/sub_serial_pkg.sv
// rtl/sub_serial_pkg.sv - shared state encoding and default width for the serial subtractor
package sub_serial_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fsub1.sv
// rtl/fsub1.sv - combinational 1-bit full subtractor (a - b - bin)
module fsub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub8_serial.sv
// rtl/sub8_serial.sv - bit-serial unsigned subtractor, LSB first, start/busy/done handshake
module sub8_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             borrow
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] r_sr_q, r_sr_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             d_w;
  logic             bout_w;
  logic [WIDTH-1:0] res_w;
  logic             last_w;

  fsub1 u_fsub1 (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .d    (d_w),
    .bout (bout_w)
  );

  // Partial result holds the WIDTH-1 bits already produced; the new bit enters at the MSB.
  assign res_w  = {d_w, r_sr_q};
  assign last_w = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    r_sr_d   = r_sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        busy_d = 1'b0;
        if (start) begin
          a_sr_d  = in0;
          b_sr_d  = in1;
          r_sr_d  = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        r_sr_d = res_w[WIDTH-1:1];
        br_d   = bout_w;
        cnt_d  = cnt_q + CNT_W'(1);
        // out only moves on the final bit so it stays stable through the whole operation.
        if (last_w) begin
          out_d    = res_w;
          borrow_d = bout_w;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_sr_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      r_sr_q   <= r_sr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign out    = out_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_sub8_serial.sv
// tb/tb_sub8_serial.sv - self-checking bench for sub8_serial
module tb_sub8_serial;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic       borrow;

  int n_chk;
  int n_fail;
  int last_out;
  int last_bw;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    logic       exp_bw;
  } vec_t;

  vec_t vecs[8];

  sub8_serial dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .in0    (in0),
    .in1    (in1),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .borrow (borrow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Start one operation, follow it to done, and check result, latency and stability of out.
  task automatic op(input logic [7:0] a, input logic [7:0] b,
                    input int exp_out, input int exp_bw, input string nm);
    int cyc;
    int busy_cnt;
    @(negedge clock);
    start = 1'b1;
    in0   = a;
    in1   = b;
    @(posedge clock);
    #1;
    start    = 1'b0;
    in0      = 8'($urandom);
    in1      = 8'($urandom);
    busy_cnt = int'(busy);
    cyc      = 0;
    while (!done && cyc < 40) begin
      chk({nm, " out_hold"}, int'(out), last_out);
      @(negedge clock);
      in0 = 8'($urandom);
      in1 = 8'($urandom);
      @(posedge clock);
      #1;
      cyc++;
      if (!done) busy_cnt += int'(busy);
    end
    chk({nm, " latency"}, cyc, 8);
    chk({nm, " busy_cycles"}, busy_cnt, 8);
    chk({nm, " out"}, int'(out), exp_out);
    chk({nm, " borrow"}, int'(borrow), exp_bw);
    last_out = exp_out;
    last_bw  = exp_bw;
    @(posedge clock);
    #1;
    chk({nm, " done_pulse_fell"}, int'(done), 0);
  endtask

  initial begin
    int a;
    int b;
    int cyc;
    int pulses;
    int seen_out;
    n_chk    = 0;
    n_fail   = 0;
    last_out = 0;
    last_bw  = 0;
    reset    = 1'b1;
    start    = 1'b0;
    in0      = '0;
    in1      = '0;

    vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0};
    vecs[1] = '{8'd5,   8'd9,   8'd252, 1'b1};
    vecs[2] = '{8'hFF,  8'h00,  8'hFF,  1'b0};
    vecs[3] = '{8'hA5,  8'hA5,  8'h00,  1'b0};
    vecs[4] = '{8'h00,  8'h01,  8'hFF,  1'b1};
    vecs[5] = '{8'h00,  8'hFF,  8'h01,  1'b1};
    vecs[6] = '{8'h80,  8'h7F,  8'h01,  1'b0};
    vecs[7] = '{8'h7F,  8'h80,  8'hFF,  1'b1};

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset out", int'(out), 0);
    chk("reset borrow", int'(borrow), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);

    for (int i = 0; i < 8; i++) begin
      op(vecs[i].a, vecs[i].b, int'(vecs[i].exp_out), int'(vecs[i].exp_bw),
         $sformatf("vec%0d", i));
    end

    // Restart attempts during SHIFT must be ignored.
    @(negedge clock);
    start = 1'b1;
    in0   = 8'd200;
    in1   = 8'd1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    pulses   = 0;
    seen_out = -1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      if (c >= 2 && c <= 5) begin
        start = 1'b1;
        in0   = 8'd3;
        in1   = 8'd4;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      if (done) begin
        pulses++;
        seen_out = int'(out);
        chk("ignore borrow", int'(borrow), 0);
      end
    end
    start = 1'b0;
    chk("ignore pulses", pulses, 1);
    chk("ignore out", seen_out, 199);
    last_out = 199;
    last_bw  = 0;

    // Back-to-back: 50-30 then 10-20 accepted in the DONE cycle.
    @(negedge clock);
    start = 1'b1;
    in0   = 8'd50;
    in1   = 8'd30;
    @(posedge clock);
    #1;
    start = 1'b0;
    cyc   = 0;
    while (!done && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk("b2b first latency", cyc, 8);
    chk("b2b first out", int'(out), 20);
    chk("b2b first borrow", int'(borrow), 0);
    @(negedge clock);
    start = 1'b1;
    in0   = 8'd10;
    in1   = 8'd20;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("b2b no idle busy", int'(busy), 1);
    chk("b2b done dropped", int'(done), 0);
    chk("b2b out held", int'(out), 20);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk("b2b spacing", cyc, 9);
    chk("b2b second out", int'(out), 246);
    chk("b2b second borrow", int'(borrow), 1);
    last_out = 246;
    last_bw  = 1;

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clock);
    start = 1'b1;
    in0   = 8'd100;
    in1   = 8'd37;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("async busy", int'(busy), 0);
    chk("async done", int'(done), 0);
    chk("async out", int'(out), 0);
    chk("async borrow", int'(borrow), 0);
    @(negedge clock);
    reset = 1'b0;
    last_out = 0;
    last_bw  = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("post reset idle busy", int'(busy), 0);
    op(8'd7, 8'd3, 4, 0, "post reset 7-3");

    // Random operands against arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      op(8'(a), 8'(b), (a - b + 256) % 256, (a < b) ? 1 : 0, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sub8_serial.md
Name: sub8_serial

Overview:
- Bit-serial unsigned subtractor, out = in0 - in1, with a start/busy/done handshake.
- Complements the registered 8-bit adder in the energy-characterization suite. It is the inverse arithmetic direction, built as a multi-cycle datapath so energy per operation can be compared against the single-cycle adder.
- Operands are captured on start, one bit per clock is processed LSB-first, and the result is held until the next start.

Parameters:
- WIDTH, 8, operand/result width in bits (must be >= 2).
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived; do not override).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clock edge; accepted only in IDLE or DONE
- in0  input  WIDTH  minuend; sampled together with an accepted start
- in1  input  WIDTH  subtrahend; sampled together with an accepted start
- busy  output  1  high while in SHIFT
- done  output  1  single-cycle pulse when the result is valid
- out  output  WIDTH  difference modulo 2^WIDTH; held stable from done until the next accepted start completes
- borrow  output  1  final borrow; 1 iff in0 < in1 (unsigned); valid and held with out

Behaviour:
- Reset is asynchronous, active-high, and overrides everything, including mid-operation:
  - state = IDLE; busy = 0; done = 0; out = 0; borrow = 0; counter = 0; operand shift registers = 0.
- FSM states: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - start = 1 → load a_sr = in0, b_sr = in1, br = 0, cnt = 0; go to SHIFT; busy = 1 next cycle.
  - out and borrow keep their previous values.
- SHIFT, each edge:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift d into the result register from the MSB side; shift a_sr and b_sr right by 1.
  - cnt increments by 1.
  - On the edge where cnt == WIDTH-1: the last bit is processed; out takes the full result, borrow = br_next; go to DONE; busy = 0; done = 1.
  - start is ignored throughout SHIFT (no restart, no operand reload).
- DONE: lasts exactly one cycle (done = 1).
  - start = 1 → accepted exactly as from IDLE (back-to-back operation).
  - Otherwise → IDLE.
  - done falls on the next edge in either case.
- Latency: start is accepted at edge E0; done is high in the cycle following edge E0+WIDTH, i.e. WIDTH edges after acceptance. Throughput is one result per WIDTH+1 cycles when back-to-back.
- During SHIFT, out must not change. The result shifts through an internal register; out is updated only on the final SHIFT edge.
- Arithmetic:
  - Unsigned operands; out is modulo 2^WIDTH; no saturation.
  - borrow equals the inverted carry of in0 + ~in1 + 1.
- Changes on in0/in1 while not being sampled have no effect.

Decomposition:
- Shared package sub_serial_pkg:
  - state enum {IDLE, SHIFT, DONE} (2-bit encoding)
  - default WIDTH constant of 8
- One natural sub-module: fsub1, a combinational 1-bit full subtractor (a, b, bin → d, bout) instantiated once in the SHIFT datapath.
- Counter, FSM and shift registers stay in sub8_serial.

Test Plan:
- Apply reset, release, wait 3 cycles → out=0, borrow=0, busy=0, done=0. Then start with in0=100, in1=37 → busy high for 8 cycles, done pulse 8 edges after acceptance, out=63, borrow=0.
- in0=5, in1=9 → out=252 (0xFC), borrow=1; in0=0xFF, in1=0x00 → out=0xFF, borrow=0; in0=in1=0xA5 → out=0, borrow=0.
- Start 200-1; re-assert start with in0=3, in1=4 during cycles 2-5 of SHIFT → ignored; out=199, borrow=0; exactly one done pulse.
- Back-to-back: hold start in DONE cycle with 10-20 → second op accepted with no IDLE cycle; first done shows 50-30 = 20; second done shows 246 (0xF6), borrow=1; spacing 9 cycles.
- Assert reset asynchronously (mid-cycle) at SHIFT bit 4 → busy/done/out/borrow go 0 immediately without a clock edge. After release, state is IDLE, and a fresh 7-3 gives out=4.
- Randomized check of 1000 operand pairs against the reference model (in0 - in1) mod 256 and (in0 < in1).
